// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct
// fields, ALU control words and datapath select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States whose exit edge completes an instruction.
  function automatic logic is_retire(input state_e s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
           (s == S_BRANCH) || (s == S_ADDIWB) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field to the ALU control word and flags unsupported functs.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       legal
);

  always_comb begin
    alucontrol = ALU_ADD;
    legal      = 1'b1;
    case (funct)
      F_ADD:   alucontrol = ALU_ADD;
      F_SUB:   alucontrol = ALU_SUB;
      F_AND:   alucontrol = ALU_AND;
      F_OR:    alucontrol = ALU_OR;
      F_SLT:   alucontrol = ALU_SLT;
      default: legal      = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle MIPS datapath, plus a retired-instruction
// counter. Outputs decode the registered state; pcen also folds in the zero flag.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int RESET_PC_HOLD = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [2:0]       alucontrol,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       dbg_state
);

  state_e           state_q, state_d;
  logic             hold_q, hold_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             pcwrite, branch, retire;
  logic [2:0]       dec_alu;
  logic             dec_legal;

  alu_decoder u_alu_decoder (
    .funct      (funct),
    .alucontrol (dec_alu),
    .legal      (dec_legal)
  );

  always_comb begin
    state_d    = S_FETCH;
    hold_d     = hold_q;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RT;
    alucontrol = ALU_ADD;
    pcsrc      = PC_ALU;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite = 1'b1;
        alusrcb = SRCB_FOUR;
        pcwrite = (hold_q == 1'b0);
        hold_d  = 1'b0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is examined.
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (dec_legal) state_d = S_EXECUTE;
            else           illegal = 1'b1;
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = dec_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PC_ALUOUT;
        branch     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset forces the FETCH selects with every enable low.
    if (reset) begin
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_FOUR;
      alucontrol = ALU_ADD;
      pcsrc      = PC_ALU;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      illegal    = 1'b0;
    end
    pcen = pcwrite | (branch & zero);
  end

  assign retire    = is_retire(state_q) & ~reset;
  assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      hold_q    <= (RESET_PC_HOLD != 0);
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      instret_q <= instret_d;
    end
  end

  assign instret   = instret_q;
  assign dbg_state = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a multicycle version of the MIPS datapath, sharing one ALU and one unified memory across instruction steps.
- Each state issues mux selects, write enables and the 3-bit ALU control word.
- Replaces the single-cycle combinational decoder. Sits beside the datapath; reads opcode, funct and the ALU zero flag.
- Also keeps an instruction counter that increments on each retired instruction, for performance checks.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- RESET_PC_HOLD, 1, number of cycles after reset release with PC write suppressed (0 or 1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag, same cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write enable
- irwrite  out  1  instruction register load
- regdst  out  1  destination select: 0 = rt, 1 = rd
- memtoreg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = signimm, 11 = signimm<<2
- alucontrol  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC register enable
- illegal  out  1  one-cycle pulse on an unsupported op or funct
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset and clocking:
  - Single clock clk. Synchronous, active-high reset. No asynchronous paths.
  - On reset: state = FETCH, instret = 0, hold counter = RESET_PC_HOLD.
  - While reset is high, every enable (memwrite, irwrite, regwrite, pcen) and illegal are forced 0; the selects take FETCH values.
  - Reset mid-instruction aborts the instruction; instret is not incremented.
- Outputs:
  - All outputs decode only the registered state.
  - Exception: pcen = pcwrite | (branch & zero), where pcwrite and branch are internal decodes.
  - Any select not listed for a state is 0; alucontrol defaults to 010.
- States and actions:
  - FETCH: iord 0, irwrite 1, alusrca 0, alusrcb 01, ADD, pcsrc 00, pcwrite 1 (suppressed while hold counter ≠ 0; counter decrements). Next state DECODE.
  - DECODE: alusrca 0, alusrcb 11, ADD (precomputes branch target).
    - op 100011 or 101011 → MEMADR
    - op 000000 with a legal funct → EXECUTE
    - op 000100 → BRANCH
    - op 001000 → ADDIEX
    - op 000010 → JUMP
    - otherwise → FETCH, with illegal = 1 in this cycle
  - MEMADR: alusrca 1, alusrcb 10, ADD. lw → MEMRD; sw → MEMWR.
  - MEMRD: iord 1. Next MEMWB.
  - MEMWB: regdst 0, memtoreg 1, regwrite 1. Retires. Next FETCH.
  - MEMWR: iord 1, memwrite 1. Retires. Next FETCH.
  - EXECUTE: alusrca 1, alusrcb 00, alucontrol from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Next ALUWB.
  - ALUWB: regdst 1, memtoreg 0, regwrite 1. Retires. Next FETCH.
  - BRANCH: alusrca 1, alusrcb 00, SUB, pcsrc 01, branch 1. Retires whether taken or not. Next FETCH.
  - ADDIEX: alusrca 1, alusrcb 10, ADD. Next ADDIWB.
  - ADDIWB: regdst 0, memtoreg 0, regwrite 1. Retires. Next FETCH.
  - JUMP: pcsrc 10, pcwrite 1. Retires. Next FETCH.
- Cycle counts per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- instret:
  - Increments by 1 on the clock edge leaving a retiring state.
  - Wraps modulo 2^CNT_W with no saturation.
  - Illegal instructions do not count.
- Unreachable state encodings go to FETCH on the next edge with all enables 0.
- Register-file write of register 0 is filtered by the register file, not by this block.

Decomposition:
- ctrl_pkg holds:
  - state enum (4 bits, 12 states)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT
  - ALU control codes ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT
  - alusrcb and pcsrc select codes
- One sub-module, alu_decoder: combinational map of funct to {alucontrol, legal}. Used by EXECUTE and by DECODE's legality check.

Test Plan:
- Reset held 3 cycles, then released with op = 100011 (lw) → FETCH with pcen 0 (hold = 1), DECODE, MEMADR (alusrcb 10), MEMRD (iord 1), MEMWB (regwrite 1, memtoreg 1); instret = 1 after 5 cycles.
- sw (op 101011) → memwrite high for exactly 1 cycle, in cycle 4 with iord 1; regwrite never asserted.
- R-type sequence add, sub, and, or, slt → alucontrol in EXECUTE = 010, 110, 000, 001, 111; ALUWB regdst 1; instret increments by 5.
- beq: zero = 1 in BRANCH → pcen 1, pcsrc 01. zero = 0 → pcen 0. Both take 3 cycles and both retire.
- j (op 000010) → JUMP with pcsrc 10 and pcen 1, 3 cycles total. op 111111, or R-type funct 000000 → illegal pulses 1 cycle in DECODE, back to FETCH, instret unchanged.
- Reset asserted in MEMWR → memwrite 0 in that cycle, state FETCH next, instret reset to 0.
